seven_seg_scan_driver: RTL

//  Time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display.
//  - Prescales `clock` into a digit-slot tick and rotates the active-low digit enable.
//  - Decodes each digit's hex nibble to active-low segments.
//  - Value updates are tear-free: a new value is applied only at frame boundaries.
//  - Consumes values from the counter/BCD logic upstream; drives the board pins directly.

---
 rtl/seven_seg_pkg.sv | 28 ++
 rtl/seven_seg_decoder.sv | 31 +++
 rtl/seven_seg_scan_driver.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a} for a common-anode display.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // All digit enables inactive; slice [NUM_DIGITS-1:0] at the use site.
  localparam int MAX_DIGITS = 32;
  localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;

endpackage

// File: rtl/seven_seg_decoder.sv
// Hex nibble to active-low seven-segment pattern.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  // Pure lookup of the hex glyph.
  always_comb begin
    case (nibble)
      4'h0: segments = SEG_0;
      4'h1: segments = SEG_1;
      4'h2: segments = SEG_2;
      4'h3: segments = SEG_3;
      4'h4: segments = SEG_4;
      4'h5: segments = SEG_5;
      4'h6: segments = SEG_6;
      4'h7: segments = SEG_7;
      4'h8: segments = SEG_8;
      4'h9: segments = SEG_9;
      4'hA: segments = SEG_A;
      4'hB: segments = SEG_B;
      4'hC: segments = SEG_C;
      4'hD: segments = SEG_D;
      4'hE: segments = SEG_E;
      default: segments = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with tear-free updates.
// New values are held in a shadow register and promoted to the display
// register only at a frame wrap, so a frame never mixes old and new digits.
// Optional build macro SEVEN_SEG_LZ_BLANK_EN enables leading-zero blanking.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic                    pending,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic [6:0]              segments,
  output logic                    dp
);

  localparam int CNT_W  = $clog2(PRESCALE);
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0]        cnt;
  logic [SLOT_W-1:0]       slot;
  logic [4*NUM_DIGITS-1:0] shadow_value;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] display_value;
  logic [NUM_DIGITS-1:0]   display_dp;

  logic                    tick;
  logic                    wrap;
  logic                    in_blank;
  logic [3:0]              sel_nibble;
  logic                    sel_dp;
  logic                    sel_lz;
  logic [NUM_DIGITS-1:0]   sel_digit;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [6:0]              dec_segments;

  assign tick     = (cnt == CNT_W'(PRESCALE - 1));
  assign wrap     = tick && (slot == SLOT_W'(NUM_DIGITS - 1));
  assign in_blank = (cnt < CNT_W'(BLANK_CYCLES));

  // Prescaler and slot rotation.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      slot <= '0;
    end else if (tick) begin
      cnt  <= '0;
      slot <= wrap ? '0 : slot + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow/display handshake; a load coinciding with a wrap bypasses the shadow.
  always_ff @(posedge clock) begin
    if (reset) begin
      shadow_value  <= '0;
      shadow_dp     <= '0;
      display_value <= '0;
      display_dp    <= '0;
      pending       <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= wrap && (pending || load);
      if (wrap && load) begin
        shadow_value  <= value_in;
        shadow_dp     <= dp_in;
        display_value <= value_in;
        display_dp    <= dp_in;
        pending       <= 1'b0;
      end else if (wrap && pending) begin
        display_value <= shadow_value;
        display_dp    <= shadow_dp;
        pending       <= 1'b0;
      end else if (load) begin
        shadow_value <= value_in;
        shadow_dp    <= dp_in;
        pending      <= 1'b1;
      end
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // A slot is a leading zero when it and every higher slot hold 0; slot 0 always shows.
  always_comb begin
    logic zero_above;
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above && (display_value[4*k +: 4] == 4'h0);
      lz_blank[k] = zero_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  // Select the active slot's nibble, dp, blanking flag and enable pattern.
  always_comb begin
    sel_nibble = 4'h0;
    sel_dp     = 1'b0;
    sel_lz     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_digit[i] = (slot != SLOT_W'(i));
      if (slot == SLOT_W'(i)) begin
        sel_nibble = display_value[4*i +: 4];
        sel_dp     = display_dp[i];
        sel_lz     = lz_blank[i];
      end
    end
  end

  seven_seg_decoder u_decoder (
    .nibble   (sel_nibble),
    .segments (dec_segments)
  );

  // Registered pin drivers; digit, segments and dp always update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      digit    <= DIGIT_OFF[NUM_DIGITS-1:0];
      segments <= SEG_BLANK;
      dp       <= 1'b1;
    end else if (in_blank) begin
      digit    <= DIGIT_OFF[NUM_DIGITS-1:0];
      segments <= SEG_BLANK;
      dp       <= 1'b1;
    end else begin
      digit    <= sel_digit;
      segments <= sel_lz ? SEG_BLANK : dec_segments;
      dp       <= ~sel_dp;
    end
  end

endmodule
